// File: rtl/uart_apb_regs.sv
// ---------------------------------------------------------------------------
// uart_apb_regs
//   APB3 slave register front-end for the buffered UART (uart_fifo).
//   CPU accesses to DATA become single-cycle TX pushes / RX pops. PREADY is
//   held off for POP_WAIT cycles after a push/pop so that the FIFO status
//   flags have settled before the CPU can issue the next access. Also holds
//   STATUS, CTRL, an RX idle-timeout counter and a maskable level interrupt.
//
//   Register map (PADDR, word select):
//     0 DATA    R: rx_byte + pop     W: push PWDATA[7:0]
//     1 STATUS  R: {to_flag, intr, busy, tx_fifo_full, rx_fifo_empty}
//               W: bit4 write-one-to-clear to_flag
//     2 CTRL    [1:0] RW  (bit0 RX-not-empty irq enable, bit1 timeout irq enable)
//     3 TIMEOUT [15:0] RW (0 disables the idle timeout flag)
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA  APB3 request
//   PRDATA/PREADY/PSLVERR    APB3 response (all registered)
//   tx_byte, transmit        TX FIFO push data / 1-cycle push strobe
//   rx_fifo_pop              1-cycle RX FIFO pop strobe
//   rx_byte                  RX FIFO head
//   rx_fifo_empty, tx_fifo_full, busy  uart_fifo status
//   intr                     registered level interrupt
//
// POP_WAIT must be at least 1.
// ---------------------------------------------------------------------------
module uart_apb_regs #(
  parameter int POP_WAIT = 3,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    PADDR,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  output logic [7:0]    tx_byte,
  output logic          transmit,
  output logic          rx_fifo_pop,
  input  logic [7:0]    rx_byte,
  input  logic          rx_fifo_empty,
  input  logic          tx_fifo_full,
  input  logic          busy,
  output logic          intr
);

  // Outputs are registered: the decision taken in a state becomes visible
  // in the following cycle. IDLE therefore takes the access decision, and
  // ACT is the cycle in which its strobe / zero-wait PREADY is visible.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACT  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(POP_WAIT - 1);

  state_t          state_r, state_s;
  logic [7:0]      wait_cnt_r, wait_cnt_s;
  logic            abort_r, abort_s;
  logic [1:0]      ctrl_r, ctrl_s;
  logic [15:0]     timeout_r, timeout_s;
  logic            to_flag_r, to_flag_s;
  logic [15:0]     idle_cnt_r, idle_cnt_s;

  logic [DW-1:0]   rdata_s;
  logic            ready_s;
  logic            slverr_s;
  logic [7:0]      tx_byte_s;
  logic            transmit_s;
  logic            pop_s;
  logic            intr_s;
  logic            w1c_s;
  logic            to_set_s;
  logic [DW-1:0]   rd_val_s;

  // Read mux for the zero-wait registers.
  always_comb begin
    rd_val_s = '0;
    case (PADDR)
      2'd1:    rd_val_s[4:0]  = {to_flag_r, intr, busy, tx_fifo_full, rx_fifo_empty};
      2'd2:    rd_val_s[1:0]  = ctrl_r;
      2'd3:    rd_val_s[15:0] = timeout_r;
      default: rd_val_s       = '0;
    endcase
  end

  // FSM next-state and next values of all registered outputs/registers.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    abort_s    = abort_r;
    rdata_s    = PRDATA;
    ready_s    = PREADY;
    slverr_s   = PSLVERR;
    tx_byte_s  = tx_byte;
    transmit_s = 1'b0;
    pop_s      = 1'b0;
    ctrl_s     = ctrl_r;
    timeout_s  = timeout_r;
    w1c_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (PSEL && PENABLE) begin
          state_s = ST_ACT;
          if (PADDR == 2'd0) begin
            if (PWRITE) begin
              if (!tx_fifo_full) begin
                tx_byte_s  = PWDATA[7:0];
                transmit_s = 1'b1;
              end else begin
                ready_s  = 1'b1;
                slverr_s = 1'b1;
              end
            end else begin
              if (!rx_fifo_empty) begin
                rdata_s = {{(DW-8){1'b0}}, rx_byte};
                pop_s   = 1'b1;
              end else begin
                rdata_s  = '0;
                ready_s  = 1'b1;
                slverr_s = 1'b1;
              end
            end
          end else begin
            ready_s  = 1'b1;
            slverr_s = 1'b0;
            if (PWRITE) begin
              rdata_s = '0;
              case (PADDR)
                2'd1:    w1c_s     = PWDATA[4];
                2'd2:    ctrl_s    = PWDATA[1:0];
                2'd3:    timeout_s = PWDATA[15:0];
                default: w1c_s     = 1'b0;
              endcase
            end else begin
              rdata_s = rd_val_s;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ACT: begin
        // PREADY already high means a zero-wait or error access finished.
        if (PREADY) begin
          state_s  = ST_DONE;
          ready_s  = 1'b0;
          slverr_s = 1'b0;
          rdata_s  = '0;
        end else begin
          state_s    = ST_WAIT;
          wait_cnt_s = 8'd0;
          abort_s    = ~PSEL;
        end
      end

      ST_WAIT: begin
        // A master that drops PSEL here gets no PREADY; the FIFO action
        // already happened and is not repeated.
        if (wait_cnt_r == WAIT_LAST) begin
          wait_cnt_s = 8'd0;
          abort_s    = 1'b0;
          if (abort_r || !PSEL) begin
            state_s = ST_IDLE;
            rdata_s = '0;
          end else begin
            state_s  = ST_DONE;
            ready_s  = 1'b1;
            slverr_s = 1'b0;
          end
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
          abort_s    = abort_r | ~PSEL;
        end
      end

      ST_DONE: begin
        // Hold here while PENABLE stays high so a held access is not replayed.
        ready_s  = 1'b0;
        slverr_s = 1'b0;
        rdata_s  = '0;
        if (!PENABLE) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end

      default: begin
        state_s  = ST_IDLE;
        ready_s  = 1'b0;
        slverr_s = 1'b0;
        rdata_s  = '0;
        abort_s  = 1'b0;
      end
    endcase
  end

  // Idle timeout counter, sticky timeout flag and interrupt level.
  always_comb begin
    to_set_s = (timeout_r != 16'd0) && (idle_cnt_r == timeout_r);

    if (rx_fifo_empty || pop_s) begin
      idle_cnt_s = 16'd0;
    end else if (idle_cnt_r != 16'hFFFF) begin
      idle_cnt_s = idle_cnt_r + 16'd1;
    end else begin
      idle_cnt_s = idle_cnt_r;
    end

    // Setting wins over a clear in the same cycle.
    if (to_set_s) begin
      to_flag_s = 1'b1;
    end else if (w1c_s || pop_s) begin
      to_flag_s = 1'b0;
    end else begin
      to_flag_s = to_flag_r;
    end

    intr_s = (ctrl_r[0] & ~rx_fifo_empty) | (ctrl_r[1] & to_flag_r);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 8'd0;
      abort_r     <= 1'b0;
      ctrl_r      <= 2'd0;
      timeout_r   <= 16'd0;
      to_flag_r   <= 1'b0;
      idle_cnt_r  <= 16'd0;
      PRDATA      <= '0;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
      tx_byte     <= 8'd0;
      transmit    <= 1'b0;
      rx_fifo_pop <= 1'b0;
      intr        <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      abort_r     <= abort_s;
      ctrl_r      <= ctrl_s;
      timeout_r   <= timeout_s;
      to_flag_r   <= to_flag_s;
      idle_cnt_r  <= idle_cnt_s;
      PRDATA      <= rdata_s;
      PREADY      <= ready_s;
      PSLVERR     <= slverr_s;
      tx_byte     <= tx_byte_s;
      transmit    <= transmit_s;
      rx_fifo_pop <= pop_s;
      intr        <= intr_s;
    end
  end

endmodule

// File: tb/tb_uart_apb_regs.sv
// ---------------------------------------------------------------------------
// tb_uart_apb_regs
//   Directed, table-driven bench for uart_apb_regs: a vector table of APB
//   accesses with hand-computed responses, plus hand-written sequences for
//   reset, idle timeout, interrupt lag, reset mid-transfer, PSEL drop and
//   held PENABLE.
// ---------------------------------------------------------------------------
module tb_uart_apb_regs;

  logic        clk;
  logic        rst;
  logic [1:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PWDATA;
  logic [15:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        rx_fifo_pop;
  logic [7:0]  rx_byte;
  logic        rx_fifo_empty;
  logic        tx_fifo_full;
  logic        busy;
  logic        intr;

  int n_tests = 0;
  int n_fail  = 0;

  uart_apb_regs #(.POP_WAIT(3), .DW(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .PADDR         (PADDR),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PWRITE        (PWRITE),
    .PWDATA        (PWDATA),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .tx_byte       (tx_byte),
    .transmit      (transmit),
    .rx_fifo_pop   (rx_fifo_pop),
    .rx_byte       (rx_byte),
    .rx_fifo_empty (rx_fifo_empty),
    .tx_fifo_full  (tx_fifo_full),
    .busy          (busy),
    .intr          (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  rxb;
    logic        empty;
    logic        full;
    logic        bsy;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_ntx;
    int          exp_npop;
    logic [7:0]  exp_txb;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One APB transfer; reports latency (cycles from PENABLE to PREADY,
  // -1 on timeout), response, and strobe activity during and after it.
  task automatic apb(input logic wr, input logic [1:0] addr, input logic [15:0] wdata,
                     input int hold,
                     output logic [15:0] rdata, output logic err, output int lat,
                     output int ntx, output int npop, output logic [7:0] txb,
                     output logic both);
    logic done;
    rdata = 16'h0; err = 1'b0; lat = -1; ntx = 0; npop = 0; txb = 8'h0;
    both = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    for (int i = 1; i <= 20 && !done; i++) begin
      @(posedge clk); #1;
      if (transmit) begin ntx++; txb = tx_byte; end
      if (rx_fifo_pop) npop++;
      if (transmit && rx_fifo_pop) both = 1'b1;
      if (PREADY) begin
        lat = i; rdata = PRDATA; err = PSLVERR; done = 1'b1;
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (transmit) ntx++;
      if (rx_fifo_pop) npop++;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (transmit) ntx++;
      if (rx_fifo_pop) npop++;
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          ntx;
    int          npop;
    int          cnt_a;
    int          cnt_b;
    logic [7:0]  txb;
    logic        both;

    //            wr    addr   wdata     rxb    emp   full  bsy   rdata     err   lat ntx pop txb
    vecs[0]  = '{1'b1, 2'd0, 16'h0041, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 5, 1, 0, 8'h41};
    vecs[1]  = '{1'b1, 2'd0, 16'h00AB, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1, 0, 0, 8'h00};
    vecs[2]  = '{1'b0, 2'd0, 16'h0000, 8'h5A, 1'b0, 1'b0, 1'b0, 16'h005A, 1'b0, 5, 0, 1, 8'h00};
    vecs[3]  = '{1'b0, 2'd0, 16'h0000, 8'h5A, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 0, 0, 8'h00};
    vecs[4]  = '{1'b1, 2'd2, 16'h0003, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 8'h00};
    vecs[5]  = '{1'b0, 2'd2, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1, 0, 0, 8'h00};
    vecs[6]  = '{1'b1, 2'd3, 16'h1234, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 8'h00};
    vecs[7]  = '{1'b0, 2'd3, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 1, 0, 0, 8'h00};
    vecs[8]  = '{1'b0, 2'd1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0007, 1'b0, 1, 0, 0, 8'h00};
    vecs[9]  = '{1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b0, 1, 0, 0, 8'h00};
    vecs[10] = '{1'b1, 2'd2, 16'h00FC, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 8'h00};
    vecs[11] = '{1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 8'h00};
    vecs[12] = '{1'b1, 2'd3, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 8'h00};
    vecs[13] = '{1'b1, 2'd0, 16'hFF77, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 5, 1, 0, 8'h77};
    vecs[14] = '{1'b0, 2'd1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1, 0, 0, 8'h00};
    vecs[15] = '{1'b1, 2'd1, 16'h0010, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 8'h00};

    rst = 1'b0; PADDR = 2'd0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PWDATA = 16'h0; rx_byte = 8'h0; rx_fifo_empty = 1'b1; tx_fifo_full = 1'b0; busy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {8'h0, PRDATA, PREADY, PSLVERR, transmit, rx_fifo_pop, intr, 3'b0},
          32'h0);
    check("reset_tx_byte", {24'h0, tx_byte}, 32'h0);
    rst = 1'b1;

    // Table of single APB accesses
    for (int v = 0; v < 16; v++) begin
      rx_byte = vecs[v].rxb; rx_fifo_empty = vecs[v].empty;
      tx_fifo_full = vecs[v].full; busy = vecs[v].bsy;
      apb(vecs[v].wr, vecs[v].addr, vecs[v].wdata, 0, rd, er, lat, ntx, npop, txb, both);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_prdata", v), {16'h0, rd}, {16'h0, vecs[v].exp_rdata});
      check($sformatf("v%0d_pslverr", v), {31'h0, er}, {31'h0, vecs[v].exp_err});
      check($sformatf("v%0d_transmits", v), ntx, vecs[v].exp_ntx);
      check($sformatf("v%0d_pops", v), npop, vecs[v].exp_npop);
      check($sformatf("v%0d_tx_and_pop", v), {31'h0, both}, 32'h0);
      if (vecs[v].exp_ntx > 0) check($sformatf("v%0d_tx_byte", v), {24'h0, txb}, {24'h0, vecs[v].exp_txb});
    end
    rx_fifo_empty = 1'b1; tx_fifo_full = 1'b0; busy = 1'b0;

    // Held PSEL/PENABLE after PREADY must not repeat the push
    apb(1'b1, 2'd0, 16'h0033, 4, rd, er, lat, ntx, npop, txb, both);
    check("held_latency", lat, 5);
    check("held_transmits", ntx, 1);

    // Idle timeout: TIMEOUT=10, CTRL=2
    apb(1'b1, 2'd3, 16'd10, 0, rd, er, lat, ntx, npop, txb, both);
    apb(1'b1, 2'd2, 16'h0002, 0, rd, er, lat, ntx, npop, txb, both);
    rx_fifo_empty = 1'b0;
    cnt_a = -1;
    for (int i = 1; i <= 20 && cnt_a < 0; i++) begin
      @(posedge clk); #1;
      if (intr) cnt_a = i;
    end
    check("timeout_intr_cycles", cnt_a, 12);
    apb(1'b0, 2'd1, 16'h0000, 0, rd, er, lat, ntx, npop, txb, both);
    check("timeout_status", {16'h0, rd}, 32'h18);
    apb(1'b1, 2'd1, 16'h0010, 0, rd, er, lat, ntx, npop, txb, both);
    check("w1c_intr_low", {31'h0, intr}, 32'h0);
    apb(1'b0, 2'd1, 16'h0000, 0, rd, er, lat, ntx, npop, txb, both);
    check("w1c_status", {16'h0, rd}, 32'h0);
    apb(1'b1, 2'd3, 16'h0000, 0, rd, er, lat, ntx, npop, txb, both);
    rx_fifo_empty = 1'b1;

    // intr follows !rx_fifo_empty with one cycle of lag when CTRL=1
    apb(1'b1, 2'd2, 16'h0001, 0, rd, er, lat, ntx, npop, txb, both);
    check("ie_idle_low", {31'h0, intr}, 32'h0);
    rx_fifo_empty = 1'b0;
    #1;
    check("ie_lag_low", {31'h0, intr}, 32'h0);
    @(posedge clk); #1;
    check("ie_rise", {31'h0, intr}, 32'h1);
    rx_fifo_empty = 1'b1;
    #1;
    check("ie_lag_high", {31'h0, intr}, 32'h1);
    @(posedge clk); #1;
    check("ie_fall", {31'h0, intr}, 32'h0);
    apb(1'b1, 2'd2, 16'h0000, 0, rd, er, lat, ntx, npop, txb, both);
    rx_fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ie_disabled", {31'h0, intr}, 32'h0);
    rx_fifo_empty = 1'b1;

    // Reset during WAIT after a push
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 2'd0; PWDATA = 16'h0099;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    check("rstmid_push", {31'h0, transmit}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    check("rstmid_outputs", {8'h0, PRDATA, PREADY, PSLVERR, transmit, rx_fifo_pop, intr, 3'b0},
          32'h0);
    check("rstmid_tx_byte", {24'h0, tx_byte}, 32'h0);
    rst = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (transmit) cnt_a++;
      if (PREADY) cnt_b++;
    end
    check("rstmid_no_replay", cnt_a, 0);
    check("rstmid_no_ready", cnt_b, 0);

    // PSEL dropped during WAIT after a pop
    rx_byte = 8'hC3; rx_fifo_empty = 1'b0;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 2'd0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    check("drop_pop", {31'h0, rx_fifo_pop}, 32'h1);
    PSEL = 1'b0; PENABLE = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rx_fifo_pop) cnt_a++;
      if (PREADY) cnt_b++;
    end
    check("drop_no_second_pop", cnt_a, 0);
    check("drop_no_ready", cnt_b, 0);
    rx_fifo_empty = 1'b1;
    apb(1'b0, 2'd2, 16'h0000, 0, rd, er, lat, ntx, npop, txb, both);
    check("drop_recover_latency", lat, 1);
    check("drop_recover_err", {31'h0, er}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
